// File: rtl/smooth_frame_pkg.sv
// smooth_frame_pkg: shared types and constants for the smoothed-sample serial transmitter.
//   tx_state_e - serialiser FSM states
//   sample_t   - queued FIFO word {seq, t, y, x}
package smooth_frame_pkg;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned SEQ_W      = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [1:0]       t;
        logic [1:0]       y;
        logic [1:0]       x;
    } sample_t;

endpackage

// File: rtl/smooth_frame_fifo.sv
// smooth_frame_fifo: synchronous first-word-fall-through FIFO of sample_t words.
//   clk, rst_n  - clock; asynchronous active-high reset (empties the FIFO)
//   push, din   - write request and data (ignored when full)
//   pop, dout   - read request (ignored when empty); dout shows the head word
//   full, empty - status flags from the registered count
//   count       - number of stored words
module smooth_frame_fifo
    import smooth_frame_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  sample_t                    din,
    output sample_t                    dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    sample_t       mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage carries no reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/smooth_frame_tx.sv
// smooth_frame_tx: accepts smoothed x/y/t samples, drops repeats of the last queued sample,
// tags each queued sample with a 2-bit sequence number and sends it as an 11-bit
// start/8 data (LSB first)/even parity/stop frame on tx.
//   clk, rst_n          - clock; asynchronous active-high reset
//   in_valid, in_ready  - sample handshake; in_ready is low while full or in reset
//   in_x, in_y, in_t    - smoothed sample fields
//   tx                  - registered serial output, idles high
//   busy                - frame in flight or FIFO non-empty
//   filt_cnt            - saturating count of dropped repeat samples
module smooth_frame_tx
    import smooth_frame_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned FILTER_EN    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_x,
    input  logic [1:0] in_y,
    input  logic [1:0] in_t,
    output logic       tx,
    output logic       busy,
    output logic [3:0] filt_cnt
);

    localparam int unsigned CW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [7:0]  BIT_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  IDX_LAST = 3'(DATA_BITS - 1);

    // Front end: filter and sequence tagging.
    logic             fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [CW-1:0]    fifo_count;
    sample_t          fifo_dout, push_word;
    logic [SEQ_W-1:0] seq_q;
    logic [5:0]       last_q, cur_sample;
    logic             last_valid_q;
    logic [3:0]       filt_cnt_q;
    logic             accept, is_dup;

    assign in_ready   = !fifo_full && !rst_n;
    assign accept     = in_valid && in_ready;
    assign cur_sample = {in_t, in_y, in_x};
    assign is_dup     = (FILTER_EN != 0) && last_valid_q && (cur_sample == last_q);
    assign fifo_push  = accept && !is_dup;
    assign push_word  = '{seq: seq_q, t: in_t, y: in_y, x: in_x};
    assign filt_cnt   = filt_cnt_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            seq_q        <= '0;
            last_q       <= '0;
            last_valid_q <= 1'b0;
            filt_cnt_q   <= '0;
        end else begin
            if (fifo_push) begin
                seq_q        <= seq_q + 1'b1;
                last_q       <= cur_sample;
                last_valid_q <= 1'b1;
            end
            if (accept && is_dup && (filt_cnt_q != 4'hF)) begin
                filt_cnt_q <= filt_cnt_q + 4'd1;
            end
        end
    end

    smooth_frame_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_word),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Serialiser.
    tx_state_e  state_q, state_d;
    logic [7:0] clk_cnt_q, clk_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic       tx_q, tx_d;
    logic       bit_end;

    assign bit_end = (clk_cnt_q == 8'd0);

    // tx_d is the level for the period that begins at the next edge, so tx is glitch-free.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;

        if (state_q != StIdle) begin
            clk_cnt_d = bit_end ? BIT_LAST : clk_cnt_q - 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_dout;
                    par_d     = ^fifo_dout;
                    clk_cnt_d = BIT_LAST;
                    tx_d      = 1'b0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_idx_q == IDX_LAST) begin
                        tx_d    = par_q;
                        state_d = StParity;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    // Back-to-back frames: reload straight into START with no idle bit.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        par_d    = ^fifo_dout;
                        tx_d     = 1'b0;
                        state_d  = StStart;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != StIdle) || (fifo_count != '0);

endmodule
